// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and helpers for the BCD game timer.
//   state_e   : controller states (2-bit encoding)
//   status_t  : registered status outputs presented on the bus
//   bcd_clamp : saturate a nibble to a legal BCD digit
package bcd_countdown_timer_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    typedef struct packed {
        logic running;
        logic done;
        logic expired;
    } status_t;

    // Nibbles above 9 are not BCD; saturate them so the count chain stays legal.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
        return (nib > BCD_MAX) ? BCD_MAX : nib;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bus of the BCD game timer.
//   master : game controller side (drives start/pause/up_mode/load/load_value)
//   slave  : timer side (drives digits/running/done/expired)
interface bcd_countdown_timer_if #(
    parameter int unsigned DIGITS = 3
) ();

    localparam int unsigned W = 4 * DIGITS;

    logic         start;
    logic         pause;
    logic         up_mode;
    logic         load;
    logic [W-1:0] load_value;
    logic [W-1:0] digits;
    logic         running;
    logic         done;
    logic         expired;

    modport master (
        output start, pause, up_mode, load, load_value,
        input  digits, running, done, expired
    );

    modport slave (
        input  start, pause, up_mode, load, load_value,
        output digits, running, done, expired
    );

endinterface

// File: rtl/bcd_countdown_timer_tick_prescaler.sv
// Step-rate prescaler for the BCD timer.
//   clk, resetn : clock, async active-low reset
//   en          : count enable (held value is kept while low)
//   clr         : synchronous clear to 0, dominates en
//   tick_c      : combinational, high in the cycle the counter sits at TICK_DIV-1 with en
module bcd_countdown_timer_tick_prescaler #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned      CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_c = en && (cnt_q == LAST);

    // Wrap on tick so steps are exactly TICK_DIV enabled cycles apart.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick_c) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Parametrised BCD game timer: counts DIGITS decimal digits down from the preset to
// zero, or up from zero to the preset, one step per TICK_DIV clocks.
//   CLOCK_50 : system clock (posedge)
//   resetn   : async active-low reset
//   bus      : slave side of bcd_countdown_timer_if
//              in : start, pause, up_mode, load, load_value
//              out: digits (packed BCD), running, done, expired (1-cycle pulse)
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int unsigned         DIGITS      = 3,
    parameter int unsigned         TICK_DIV    = 50000000,
    parameter logic [4*DIGITS-1:0] START_VALUE = 12'h100
) (
    input  logic                        CLOCK_50,
    input  logic                        resetn,
    bcd_countdown_timer_if.slave        bus
);

    localparam int unsigned W = BCD_W * DIGITS;

    state_e         state_q, state_d;
    logic           dir_up_q, dir_up_d;
    logic [W-1:0]   preset_q, preset_d;
    logic [W-1:0]   digits_q, digits_d;
    status_t        status_q, status_d;

    logic [W-1:0]   load_clamped;
    logic [W-1:0]   dec_val;
    logic [W-1:0]   inc_val;
    logic [W-1:0]   step_val;
    logic [W-1:0]   term_val;
    logic [W-1:0]   preset_eff;
    logic [DIGITS-1:0] borrow;
    logic [DIGITS-1:0] carry;
    logic           pre_en;
    logic           pre_clr;
    logic           tick_c;

    // Per-digit clamp and ripple borrow/carry chains.
    assign borrow[0] = 1'b1;
    assign carry[0]  = 1'b1;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        logic [3:0] cur;
        assign cur = digits_q[BCD_W*g +: BCD_W];

        assign load_clamped[BCD_W*g +: BCD_W] = bcd_clamp(bus.load_value[BCD_W*g +: BCD_W]);

        assign dec_val[BCD_W*g +: BCD_W] = !borrow[g] ? cur :
                                           (cur == 4'd0) ? BCD_MAX : cur - 4'd1;
        assign inc_val[BCD_W*g +: BCD_W] = !carry[g] ? cur :
                                           (cur >= BCD_MAX) ? 4'd0 : cur + 4'd1;

        if (g < int'(DIGITS) - 1) begin : g_ripple
            assign borrow[g+1] = borrow[g] && (cur == 4'd0);
            assign carry[g+1]  = carry[g] && (cur >= BCD_MAX);
        end
    end

    assign step_val = dir_up_q ? inc_val : dec_val;
    // Up-mode terminal tracks the live preset so a runtime load retargets the count.
    assign term_val = dir_up_q ? preset_q : '0;

    // A load in the same cycle as start must feed the start.
    assign preset_eff = bus.load ? load_clamped : preset_q;

    // Prescaler runs in RUN, and in PAUSED once pause drops (state catches up next edge).
    assign pre_en  = ((state_q == ST_RUN) || (state_q == ST_PAUSED)) && !bus.pause;
    assign pre_clr = bus.start;

    bcd_countdown_timer_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (CLOCK_50),
        .resetn (resetn),
        .en     (pre_en),
        .clr    (pre_clr),
        .tick_c (tick_c)
    );

    // Next-state, count and status logic.
    always_comb begin
        state_d  = state_q;
        dir_up_d = dir_up_q;
        preset_d = preset_q;
        digits_d = digits_q;
        status_d = '0;

        if (bus.load) begin
            preset_d = load_clamped;
            if (state_q == ST_IDLE) begin
                digits_d = load_clamped;
            end
        end

        if (bus.start) begin
            dir_up_d = bus.up_mode;
            digits_d = bus.up_mode ? '0 : preset_eff;
            state_d  = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN, ST_PAUSED: begin
                    if (tick_c) begin
                        digits_d = step_val;
                        state_d  = (step_val == term_val) ? ST_EXPIRED : ST_RUN;
                    end else if ((state_q == ST_RUN) && (digits_q == term_val)) begin
                        // Started already at the terminal value.
                        state_d = ST_EXPIRED;
                    end else begin
                        state_d = bus.pause ? ST_PAUSED : ST_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        status_d.running = (state_d == ST_RUN);
        status_d.done    = (state_d == ST_EXPIRED);
        status_d.expired = (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            dir_up_q <= 1'b0;
            preset_q <= START_VALUE;
            digits_q <= START_VALUE;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            dir_up_q <= dir_up_d;
            preset_q <= preset_d;
            digits_q <= digits_d;
            status_q <= status_d;
        end
    end

    assign bus.digits  = digits_q;
    assign bus.running = status_q.running;
    assign bus.done    = status_q.done;
    assign bus.expired = status_q.expired;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer (DIGITS=3, TICK_DIV=4, START_VALUE=12'h100).
// Stimulus pushes expected digit-change / expiry events with their cycle stamps;
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_bcd_countdown_timer;

    logic clk;
    logic rst_n;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        bit          is_exp;
        logic [11:0] val;
        int          at;
    } ev_t;

    ev_t exp_q[$];

    bcd_countdown_timer_if #(.DIGITS(3)) bus ();

    bcd_countdown_timer #(
        .DIGITS      (3),
        .TICK_DIV    (4),
        .START_VALUE (12'h100)
    ) dut (
        .CLOCK_50 (clk),
        .resetn   (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic push(input bit is_exp, input logic [11:0] val, input int at);
        ev_t e;
        e.is_exp = is_exp;
        e.val    = val;
        e.at     = at;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic observe(input bit is_exp, input logic [11:0] val);
        ev_t e;
        checks = checks + 1;
        if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_%s: got %h at cycle %0d with nothing expected",
                     is_exp ? "expired" : "digits", val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.is_exp !== is_exp || e.val !== val || e.at !== cyc) begin
                errors = errors + 1;
                $display("FAIL event: got %s %h at cycle %0d, expected %s %h at cycle %0d",
                         is_exp ? "expired" : "digits", val, cyc,
                         e.is_exp ? "expired" : "digits", e.val, e.at);
            end
        end
    endtask

    // Monitor: any digit change or expiry pulse is an output event.
    logic [11:0] prev;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev = bus.digits;
        end else begin
            if (bus.digits !== prev) begin
                observe(1'b0, bus.digits);
                prev = bus.digits;
            end
            if (bus.expired !== 1'b0) begin
                observe(1'b1, bus.digits);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    int c;
    int c2;

    initial begin
        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        bus.up_mode    = 1'b0;
        bus.load       = 1'b0;
        bus.load_value = '0;
        rst_n          = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_digits",  32'(bus.digits),  32'h100);
        check("rst_running", 32'(bus.running), 0);
        check("rst_done",    32'(bus.done),    0);
        check("rst_expired", 32'(bus.expired), 0);

        // 1: full countdown 100 -> 000
        c = cyc;
        bus.up_mode = 1'b0;
        bus.start   = 1'b1;
        for (int k = 1; k <= 100; k++) push(1'b0, to_bcd(100 - k), c + 1 + 4 * k);
        push(1'b1, 12'h000, c + 401);
        step();
        bus.start = 1'b0;
        check("t1_running", 32'(bus.running), 1);
        wait_until(c + 421);
        check("t1_done",    32'(bus.done),    1);
        check("t1_running_end", 32'(bus.running), 0);
        check("t1_hold",    32'(bus.digits),  32'h000);
        check("t1_drained", 32'(exp_q.size()), 0);

        // 4: preset 000, start down -> immediate expiry
        bus.load       = 1'b1;
        bus.load_value = 12'h000;
        step();
        bus.load = 1'b0;
        c = cyc;
        bus.start = 1'b1;
        push(1'b1, 12'h000, c + 2);
        step();
        bus.start = 1'b0;
        check("t4_running", 32'(bus.running), 1);
        wait_until(c + 10);
        check("t4_done",    32'(bus.done),    1);
        check("t4_running_end", 32'(bus.running), 0);
        check("t4_drained", 32'(exp_q.size()), 0);

        // 3: clamped load in IDLE, count up to 095
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("t3_reset_digits", 32'(bus.digits), 32'h100);
        c = cyc;
        bus.load       = 1'b1;
        bus.load_value = 12'h0A5;
        push(1'b0, 12'h095, c + 1);
        step();
        bus.load = 1'b0;
        step();
        check("t3_idle_running", 32'(bus.running), 0);
        c = cyc;
        bus.up_mode = 1'b1;
        bus.start   = 1'b1;
        push(1'b0, 12'h000, c + 1);
        for (int k = 1; k <= 95; k++) push(1'b0, to_bcd(k), c + 1 + 4 * k);
        push(1'b1, 12'h095, c + 381);
        step();
        bus.start = 1'b0;
        wait_until(c + 386);
        check("t3_done",    32'(bus.done),    1);
        check("t3_final",   32'(bus.digits),  32'h095);
        check("t3_drained", 32'(exp_q.size()), 0);

        // 5: load+start mid-run restarts at the new preset
        c = cyc;
        bus.up_mode = 1'b0;
        bus.start   = 1'b1;
        push(1'b0, 12'h094, c + 5);
        push(1'b0, 12'h093, c + 9);
        step();
        bus.start = 1'b0;
        wait_until(c + 10);
        c2 = cyc;
        bus.load       = 1'b1;
        bus.load_value = 12'h005;
        bus.start      = 1'b1;
        push(1'b0, 12'h005, c2 + 1);
        for (int k = 1; k <= 5; k++) push(1'b0, to_bcd(5 - k), c2 + 1 + 4 * k);
        push(1'b1, 12'h000, c2 + 21);
        step();
        bus.load  = 1'b0;
        bus.start = 1'b0;
        wait_until(c2 + 25);
        check("t5_done",    32'(bus.done),    1);
        check("t5_drained", 32'(exp_q.size()), 0);

        // 2: pause with prescaler at 2, resume without restarting the second
        bus.load       = 1'b1;
        bus.load_value = 12'h100;
        step();
        bus.load = 1'b0;
        check("t2_load_expired_digits", 32'(bus.digits), 32'h000);
        c = cyc;
        bus.start = 1'b1;
        push(1'b0, 12'h100, c + 1);
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.pause = 1'b1;
        step();
        check("t2_paused_running", 32'(bus.running), 0);
        check("t2_paused_done",    32'(bus.done),    0);
        wait_until(c + 20);
        check("t2_paused_digits",  32'(bus.digits),  32'h100);
        wait_until(c + 43);
        bus.pause = 1'b0;
        for (int k = 1; k <= 43; k++) push(1'b0, to_bcd(100 - k), c + 41 + 4 * k);
        step();
        check("t2_resumed_running", 32'(bus.running), 1);

        // 6: reset mid-count at 057
        wait_until(c + 215);
        check("t6_at_057", 32'(bus.digits), 32'h057);
        rst_n = 1'b0;
        #1;
        check("t6_rst_digits",  32'(bus.digits),  32'h100);
        check("t6_rst_running", 32'(bus.running), 0);
        check("t6_rst_done",    32'(bus.done),    0);
        check("t6_rst_expired", 32'(bus.expired), 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (20) step();
        check("t6_idle_digits",  32'(bus.digits),  32'h100);
        check("t6_idle_running", 32'(bus.running), 0);

        check("final_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
